// File: rtl/booth_mul_pkg.sv
// Shared types and constants for the Booth multiplier issue/retire controller.
// MUL_W/PROD_W describe the 8x8 signed multiplier, MUL_LAT its fixed pipeline
// depth, TAG_W the sideband tag carried alongside each operation.
package booth_mul_pkg;

  localparam int unsigned MUL_W   = 8;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned TAG_W   = 4;

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic [TAG_W-1:0]  tag;
  } mul_res_t;

  // Number of valid slots in the in-flight shift register.
  function automatic logic [2:0] vld_popcount(input logic [MUL_LAT-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < MUL_LAT; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/booth_mul_issue_if.sv
// Operand / product handshake bundle of booth_mul_issue.
//   in_*  : operand pair (md, mr, tag) with valid/ready, flowing into the block
//   out_* : signed product + tag with valid/ready, flowing out of the block
// slave is the controller's view, master the producer/consumer view.
interface booth_mul_issue_if;
  import booth_mul_pkg::*;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [MUL_W-1:0]  in_md_i;
  logic [MUL_W-1:0]  in_mr_i;
  logic [TAG_W-1:0]  in_tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [PROD_W-1:0] out_prod_o;
  logic [TAG_W-1:0]  out_tag_o;

  modport master (
    output in_valid_i, in_md_i, in_mr_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_prod_o, out_tag_o
  );

  modport slave (
    input  in_valid_i, in_md_i, in_mr_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, out_prod_o, out_tag_o
  );

endinterface

// File: rtl/booth_res_fifo.sv
// First-word-fall-through synchronous FIFO for multiplier results.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : sync clear of pointers/count; push and pop that cycle are void
//   push_i/data_i : write side (no ready; caller guarantees space)
//   pop_i         : read side accept, qualified internally with valid_o
//   valid_o/data_o: head entry, read straight from the storage registers
//   count_o       : occupancy 0..DEPTH
module booth_res_fifo
  import booth_mul_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  mul_res_t                   data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output mul_res_t                   data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  mul_res_t           mem_q [DEPTH];
  mul_res_t           mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push_ok_s, pop_ok_s;

  assign valid_o = (cnt_q != {CNT_W{1'b0}});
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Qualify push/pop: flush voids both, pop needs a head entry.
  always_comb begin
    push_ok_s = push_i & ~flush_i;
    pop_ok_s  = pop_i & valid_o & ~flush_i;
  end

  // Next-state for storage, pointers (natural wrap, DEPTH is a power of 2) and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = data_i;
    end else begin
      mem_d = mem_q;
    end
    if (flush_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; storage is cleared too so the head reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {($bits(mul_res_t)){1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  booth_res_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_ok_s),
    .count_i (cnt_q)
  );

endmodule

// File: rtl/booth_res_fifo_chk.sv
// Simulation checker for booth_res_fifo: the issue credit must make a push
// into a full FIFO impossible, so such a push is fatal.
//   clk_i, rst_ni : clock and async active-low reset
//   push_i        : effective push this cycle
//   count_i       : current FIFO occupancy
module booth_res_fifo_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             push_i,
  input logic [CNT_W-1:0] count_i
);

  property p_no_push_full;
    @(posedge clk_i) disable iff (!rst_ni) push_i |-> (count_i != CNT_W'(DEPTH));
  endproperty

  a_no_push_full: assert property (p_no_push_full)
    else $fatal(1, "booth_res_fifo: push while full");

endmodule

// File: rtl/booth_mul_issue.sv
// Issue/retire controller around the 3-stage radix-4 Booth 8x8 multiplier.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : sync discard of in-flight and buffered results
//   io            : operand in / product out handshakes (booth_mul_issue_if.slave)
//   mul_md_o/mr_o : operands to the multiplier, zero when nothing issues
//   mul_res_i     : multiplier result, MUL_LAT cycles after the drive cycle
//   inflight_o    : products currently inside the multiplier
// The multiplier cannot stall, so issue is credit based: an operation is only
// accepted when its product is guaranteed a FIFO slot on retirement.
module booth_mul_issue
  import booth_mul_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  booth_mul_issue_if.slave   io,
  output logic [MUL_W-1:0]   mul_md_o,
  output logic [MUL_W-1:0]   mul_mr_o,
  input  logic [PROD_W-1:0]  mul_res_i,
  output logic [2:0]         inflight_o
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [MUL_LAT-1:0]            vld_sr_q, vld_sr_d;
  logic [MUL_LAT-1:0][TAG_W-1:0] tag_sr_q, tag_sr_d;
  logic                          fire_s;
  logic                          in_ready_s;
  logic [2:0]                    inflight_s;
  logic [CNT_W-1:0]              fifo_cnt_s;
  logic [7:0]                    used_s;
  mul_res_t                      push_data_s;
  mul_res_t                      head_s;

  assign fire_s = io.in_valid_i & in_ready_s;

  // Credit: everything accepted but not yet popped (including the entry
  // retiring this cycle) must fit in the FIFO. No path from in_valid/out_ready.
  always_comb begin
    inflight_s = vld_popcount(vld_sr_q);
    used_s     = 8'(inflight_s) + 8'(fifo_cnt_s);
    if (flush_i) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (used_s < 8'(OUT_DEPTH));
    end
  end

  // Operands reach the multiplier only in the accept cycle.
  always_comb begin
    if (fire_s) begin
      mul_md_o = io.in_md_i;
      mul_mr_o = io.in_mr_i;
    end else begin
      mul_md_o = {MUL_W{1'b0}};
      mul_mr_o = {MUL_W{1'b0}};
    end
  end

  // Valid/tag shift registers move every cycle, mirroring the multiplier stages.
  always_comb begin
    tag_sr_d = {tag_sr_q[MUL_LAT-2:0], io.in_tag_i};
    if (flush_i) begin
      vld_sr_d = {MUL_LAT{1'b0}};
    end else begin
      vld_sr_d = {vld_sr_q[MUL_LAT-2:0], fire_s};
    end
  end

  // Tracking registers; clearing vld_sr masks whatever the unreset multiplier holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_sr_q <= {MUL_LAT{1'b0}};
      tag_sr_q <= {(MUL_LAT*TAG_W){1'b0}};
    end else begin
      vld_sr_q <= vld_sr_d;
      tag_sr_q <= tag_sr_d;
    end
  end

  assign push_data_s = {mul_res_i, tag_sr_q[MUL_LAT-1]};

  booth_res_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (vld_sr_q[MUL_LAT-1]),
    .data_i  (push_data_s),
    .pop_i   (io.out_ready_i),
    .valid_o (io.out_valid_o),
    .data_o  (head_s),
    .count_o (fifo_cnt_s)
  );

  assign io.in_ready_o = in_ready_s;
  assign io.out_prod_o = head_s.prod;
  assign io.out_tag_o  = head_s.tag;
  assign inflight_o    = inflight_s;

endmodule

// File: tb/tb_booth_mul_issue.sv
module tb_booth_mul_issue;
  import booth_mul_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  mul_md, mul_mr;
  logic [15:0] mul_res;
  logic [2:0]  inflight;

  booth_mul_issue_if bus();

  booth_mul_issue #(.OUT_DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .io         (bus),
    .mul_md_o   (mul_md),
    .mul_mr_o   (mul_mr),
    .mul_res_i  (mul_res),
    .inflight_o (inflight)
  );

  always #5 clk = ~clk;

  // Signed 8x8 -> 16 reference product.
  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] x, y;
    x = {{8{a[7]}}, a};
    y = {{8{b[7]}}, b};
    return 16'(x * y);
  endfunction

  // Behavioural stand-in for the 3-stage multiplier (no reset, like the real one).
  logic [15:0] p1 = 16'd0, p2 = 16'd0, p3 = 16'd0;
  always @(posedge clk) begin
    p1 <= smul(mul_md, mul_mr);
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_res = p3;

  typedef struct {
    logic [15:0] prod;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   outstanding = 0;
  logic [2:0] fire_hist = 3'b000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / credit monitor, sampled on the falling edge.
  initial begin
    exp_t e;
    bit   in_fire, out_fire;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        outstanding = 0;
        fire_hist   = 3'b000;
      end else begin
        check_eq("in_ready_credit", 32'(bus.in_ready_o), 32'(!flush && outstanding < 4));
        check_eq("inflight", 32'(inflight),
                 32'(int'(fire_hist[0]) + int'(fire_hist[1]) + int'(fire_hist[2])));
        if (flush) begin
          sb.delete();
          outstanding = 0;
          fire_hist   = 3'b000;
        end else begin
          in_fire  = bus.in_valid_i & bus.in_ready_o;
          out_fire = bus.out_valid_o & bus.out_ready_i;
          if (out_fire) begin
            if (sb.size() == 0) begin
              check_eq("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              check_eq("sb_prod", 32'(bus.out_prod_o), 32'(e.prod));
              check_eq("sb_tag", 32'(bus.out_tag_o), 32'(e.tag));
            end
          end
          if (in_fire) begin
            e.prod = smul(bus.in_md_i, bus.in_mr_i);
            e.tag  = bus.in_tag_i;
            sb.push_back(e);
          end
          outstanding = outstanding + int'(in_fire) - int'(out_fire);
          fire_hist   = {fire_hist[1:0], in_fire};
        end
      end
    end
  end

  // Offer one op; returns at posedge+1 after it was accepted (in_valid left high).
  task automatic send(input logic [7:0] md, input logic [7:0] mr, input logic [3:0] tag);
    bit acc;
    acc = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_md_i    = md;
    bus.in_mr_i    = mr;
    bus.in_tag_i   = tag;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clk);
      if (bus.in_ready_o) acc = 1'b1;
      @(posedge clk); #1;
    end
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 300 && !done; w++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid_o) done = 1'b1;
    end
    check_eq("drain_done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (bus.out_valid_o) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] t2_prod [3];
  logic [3:0]  t2_tag  [3];
  logic [7:0]  t3_md   [6];
  logic [7:0]  t3_mr   [6];
  int          lat, acc;

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_md_i     = 8'd0;
    bus.in_mr_i     = 8'd0;
    bus.in_tag_i    = 4'd0;
    bus.out_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check_eq("rst_out_prod", 32'(bus.out_prod_o), 32'd0);
    check_eq("rst_out_tag", 32'(bus.out_tag_o), 32'd0);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_mul_md", 32'(mul_md), 32'd0);
    check_eq("rst_mul_mr", 32'(mul_mr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: single op, latency 4 from the fire cycle
    bus.out_ready_i = 1'b1;
    check_eq("t1_idle_mul_md", 32'(mul_md), 32'd0);
    bus.in_valid_i = 1'b1;
    bus.in_md_i    = 8'd3;
    bus.in_mr_i    = 8'hFE;
    bus.in_tag_i   = 4'd5;
    @(negedge clk);
    check_eq("t1_ready", 32'(bus.in_ready_o), 32'd1);
    check_eq("t1_mul_md", 32'(mul_md), 32'd3);
    check_eq("t1_mul_mr", 32'(mul_mr), 32'hFE);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.out_valid_o) begin
        lat = k;
        break;
      end
    end
    check_eq("t1_latency", 32'(lat), 32'd4);
    check_eq("t1_prod", 32'(bus.out_prod_o), 32'hFFFA);
    check_eq("t1_tag", 32'(bus.out_tag_o), 32'd5);
    @(posedge clk); #1;
    drain();

    // T2: extremes, popped one at a time and checked against known constants
    bus.out_ready_i = 1'b0;
    t2_prod[0] = 16'h4000; t2_tag[0] = 4'd1;
    t2_prod[1] = 16'hC080; t2_tag[1] = 4'd2;
    t2_prod[2] = 16'h0000; t2_tag[2] = 4'd3;
    send(8'h80, 8'h80, 4'd1);
    send(8'h7F, 8'h80, 4'd2);
    send(8'h00, 8'h9C, 4'd3);
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_out_valid("t2_out_valid");
      check_eq("t2_prod", 32'(bus.out_prod_o), 32'(t2_prod[i]));
      check_eq("t2_tag", 32'(bus.out_tag_o), 32'(t2_tag[i]));
      @(posedge clk); #1;
      bus.out_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.out_ready_i = 1'b0;
    end
    bus.out_ready_i = 1'b1;
    drain();

    // T3: backpressure, exactly OUT_DEPTH accepted, then release
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t3_md[i] = 8'($urandom);
      t3_mr[i] = 8'($urandom);
    end
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid_i = 1'b1;
      bus.in_md_i    = t3_md[acc];
      bus.in_mr_i    = t3_mr[acc];
      bus.in_tag_i   = 4'(acc + 8);
      @(negedge clk);
      if (bus.in_ready_o) acc++;
      @(posedge clk); #1;
    end
    check_eq("t3_accepted", 32'(acc), 32'd4);
    check_eq("t3_ready_low", 32'(bus.in_ready_o), 32'd0);
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      bus.in_md_i  = t3_md[acc];
      bus.in_mr_i  = t3_mr[acc];
      bus.in_tag_i = 4'(acc + 8);
      @(negedge clk);
      if (bus.in_ready_o) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
    check_eq("t3_all_accepted", 32'(acc), 32'd6);
    drain();

    // T4: streaming random ops
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(8'($urandom), 8'($urandom), 4'($urandom));
    end
    bus.in_valid_i = 1'b0;
    drain();

    // T5: flush discards the in-flight ops
    send(8'd11, 8'd12, 4'd1);
    send(8'hF0, 8'd7, 4'd2);
    send(8'd100, 8'hFF, 4'd3);
    bus.in_valid_i = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq("t5_no_out_valid", 32'(bus.out_valid_o), 32'd0);
    end
    @(posedge clk); #1;
    send(8'hFB, 8'd9, 4'd7);
    bus.in_valid_i = 1'b0;
    drain();

    // T6: reset with results buffered and in flight (credit caps the total at 4)
    bus.out_ready_i = 1'b0;
    send(8'd5, 8'd6, 4'd1);
    send(8'd7, 8'd8, 4'd2);
    bus.in_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(8'd9, 8'd10, 4'd3);
    send(8'd11, 8'd12, 4'd4);
    bus.in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_out_valid", 32'(bus.out_valid_o), 32'd0);
    check_eq("t6_inflight", 32'(inflight), 32'd0);
    check_eq("t6_in_ready", 32'(bus.in_ready_o), 32'd1);
    check_eq("t6_out_prod", 32'(bus.out_prod_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    send(8'h81, 8'd2, 4'd9);
    bus.in_valid_i = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
